// File: rtl/pl_hazard_ctrl_pkg.sv
// Shared pipeline control codes, hazard FSM states and stage-code decode
// for the 5-stage core hazard controller.
package pl_hazard_ctrl_pkg;

  localparam logic [1:0] PL_NORMAL = 2'b00;
  localparam logic [1:0] PL_PAUSE  = 2'b01;
  localparam logic [1:0] PL_FLUSH  = 2'b10;

  typedef enum logic [2:0] {
    HZ_RUN        = 3'd0,
    HZ_LU_STALL   = 3'd1,
    HZ_MC_STALL   = 3'd2,
    HZ_MEM_FREEZE = 3'd3,
    HZ_BR_FLUSH   = 3'd4
  } hz_state_e;

  typedef struct packed {
    logic [1:0] pc;
    logic [1:0] id;
    logic [1:0] ex;
    logic [1:0] mem;
    logic [1:0] wb;
  } pl_ctrl_t;

  localparam pl_ctrl_t PL_ALL_FLUSH = '{
    PL_FLUSH, PL_FLUSH, PL_FLUSH, PL_FLUSH, PL_FLUSH
  };

  function automatic pl_ctrl_t stage_codes(hz_state_e s);
    pl_ctrl_t c;
    c = '{PL_NORMAL, PL_NORMAL, PL_NORMAL, PL_NORMAL, PL_NORMAL};
    unique case (s)
      HZ_LU_STALL:
        c = '{PL_PAUSE, PL_PAUSE, PL_FLUSH, PL_NORMAL, PL_NORMAL};
      HZ_MC_STALL:
        c = '{PL_PAUSE, PL_PAUSE, PL_PAUSE, PL_FLUSH, PL_NORMAL};
      // wb is flushed so a frozen MEM result is not written twice
      HZ_MEM_FREEZE:
        c = '{PL_PAUSE, PL_PAUSE, PL_PAUSE, PL_PAUSE, PL_FLUSH};
      HZ_BR_FLUSH:
        c = '{PL_NORMAL, PL_FLUSH, PL_FLUSH, PL_FLUSH, PL_NORMAL};
      default:
        c = '{PL_NORMAL, PL_NORMAL, PL_NORMAL, PL_NORMAL, PL_NORMAL};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pl_hazard_ctrl_fwd_select.sv
// Priority forwarding select for one EX operand.
// Lowest-index (nearest) matching source wins; x0 never forwards.
module pl_fwd_select #(
  parameter int REG_AW    = 5,
  parameter int FWD_DEPTH = 2,
  parameter int SW        = $clog2(FWD_DEPTH + 1)
) (
  input  logic [REG_AW-1:0]           rs,
  input  logic [FWD_DEPTH-1:0]        fwd_regwr,
  input  logic [FWD_DEPTH*REG_AW-1:0] fwd_rd,
  output logic [SW-1:0]               sel
);

  always_comb begin
    sel = '0;
    for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
      if (fwd_regwr[k] &&
          fwd_rd[k*REG_AW +: REG_AW] == rs &&
          rs != '0)
        sel = SW'(k + 1);
    end
  end

endmodule

// File: rtl/pl_hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use / multi-cycle /
// memory-wait stalls, branch flush and a saturating stall counter.
module pl_hazard_ctrl
  import pl_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 1,
  parameter int CNT_W     = 32
) (
  input  logic                            clk,
  input  logic                            clr_n,
  input  logic                            branch,
  input  logic                            mem_wait,
  input  logic                            ex_busy,
  input  logic                            mem2reg_ex,
  input  logic [REG_AW-1:0]               rd_ex,
  input  logic [REG_AW-1:0]               rs1_id,
  input  logic [REG_AW-1:0]               rs2_id,
  input  logic                            rs1_used,
  input  logic                            rs2_used,
  input  logic [REG_AW-1:0]               rs1_ex,
  input  logic [REG_AW-1:0]               rs2_ex,
  input  logic [FWD_DEPTH-1:0]            fwd_regwr,
  input  logic [FWD_DEPTH*REG_AW-1:0]     fwd_rd,
  output logic [$clog2(FWD_DEPTH+1)-1:0]  forward_rs1,
  output logic [$clog2(FWD_DEPTH+1)-1:0]  forward_rs2,
  output logic [1:0]                      pl_ctrl_pc,
  output logic [1:0]                      pl_ctrl_id,
  output logic [1:0]                      pl_ctrl_ex,
  output logic [1:0]                      pl_ctrl_mem,
  output logic [1:0]                      pl_ctrl_wb,
  output logic                            ex_kill,
  output logic [CNT_W-1:0]                stall_cnt
);

  localparam int LW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

  hz_state_e     state, state_nx;
  logic [LW-1:0] lu_cnt, lu_cnt_nx;
  logic          load_use;
  pl_ctrl_t      codes;

  pl_fwd_select #(
    .REG_AW    (REG_AW),
    .FWD_DEPTH (FWD_DEPTH)
  ) u_fwd_rs1 (
    .rs        (rs1_ex),
    .fwd_regwr (fwd_regwr),
    .fwd_rd    (fwd_rd),
    .sel       (forward_rs1)
  );

  pl_fwd_select #(
    .REG_AW    (REG_AW),
    .FWD_DEPTH (FWD_DEPTH)
  ) u_fwd_rs2 (
    .rs        (rs2_ex),
    .fwd_regwr (fwd_regwr),
    .fwd_rd    (fwd_rd),
    .sel       (forward_rs2)
  );

  assign load_use = mem2reg_ex && rd_ex != '0 &&
                    ((rs1_used && rs1_id == rd_ex) ||
                     (rs2_used && rs2_id == rd_ex));

  // Freeze holds lu_cnt; a branch cancels any pending load bubbles
  always_comb begin
    state_nx  = state;
    lu_cnt_nx = lu_cnt;
    if (mem_wait) begin
      state_nx = HZ_MEM_FREEZE;
    end else if (branch) begin
      state_nx  = HZ_BR_FLUSH;
      lu_cnt_nx = '0;
    end else if (ex_busy) begin
      state_nx = HZ_MC_STALL;
    end else if (load_use || lu_cnt != '0) begin
      state_nx  = HZ_LU_STALL;
      lu_cnt_nx = (lu_cnt != '0) ? lu_cnt - LW'(1)
                                 : LW'(LOAD_LAT - 1);
    end else begin
      state_nx = HZ_RUN;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state     <= HZ_RUN;
      lu_cnt    <= '0;
      stall_cnt <= '0;
    end else begin
      state  <= state_nx;
      lu_cnt <= lu_cnt_nx;
      if (state != HZ_RUN && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign codes       = clr_n ? stage_codes(state) : PL_ALL_FLUSH;
  assign pl_ctrl_pc  = codes.pc;
  assign pl_ctrl_id  = codes.id;
  assign pl_ctrl_ex  = codes.ex;
  assign pl_ctrl_mem = codes.mem;
  assign pl_ctrl_wb  = codes.wb;
  assign ex_kill     = clr_n && state == HZ_BR_FLUSH;

endmodule
